// File: rtl/vga_sync_receiver.sv
// VGA sink: recovers pixel coordinates from hsync/vsync/blank/colour and checks
// line/frame timing against the expected format, declaring lock after good frames.
`timescale 1ns/1ps
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank,
    input  logic [8:0] colour_in,
    input  logic       clear_errors,
    output logic       pixel_valid,
    output logic [8:0] colour_out,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_error,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       hsync_p0, vsync_p0, blank_p0, clear_p0;
    logic [8:0] colour_p0;
    logic       hsync_p1, vsync_p1;

    logic [9:0] h_count, pix_count, line_count, act_lines;
    logic       line_err_seen;
    state_t     state, state_nxt;
    logic [3:0] good_cnt, good_nxt;

    logic        hfall, vfall, active;
    logic [10:0] h_period;
    logic        h_sat, line_ok, timeout, line_err_now;
    logic [9:0]  pix_base, line_closed, act_closed;
    logic        frame_good, frame_bad, err_event;

    // Stage p0: input registers; p1: delayed sync copies for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_p0 <= 1'b0;
            vsync_p0 <= 1'b0;
            blank_p0 <= 1'b1;
            clear_p0 <= 1'b0;
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
        end else begin
            hsync_p0 <= hsync;
            vsync_p0 <= vsync;
            blank_p0 <= blank;
            clear_p0 <= clear_errors;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
        end
    end

    always_ff @(posedge clk) begin
        colour_p0 <= colour_in;
    end

    assign hfall    = hsync_p1 & ~hsync_p0;
    assign vfall    = vsync_p1 & ~vsync_p0;
    assign active   = ~blank_p0;
    assign h_period = {1'b0, h_count} + 11'd1;
    assign h_sat    = (h_count == 10'h3FF);
    assign line_ok  = (h_period == 11'(H_TOTAL)) &&
                      ((pix_count == 10'(H_ACTIVE)) || (pix_count == 10'd0));
    // A saturated line was already reported by the timeout; its closing edge is not re-checked
    assign timeout      = ~hfall && (h_count == 10'h3FE);
    assign line_err_now = (hfall && ~h_sat && ~line_ok) || timeout;

    assign pix_base    = hfall ? 10'd0 : pix_count;
    assign line_closed = hfall ? sat_inc10(line_count) : line_count;
    assign act_closed  = (hfall && (pix_count != 10'd0)) ? sat_inc10(act_lines) : act_lines;
    assign frame_good  = (line_closed == 10'(V_TOTAL)) && (act_closed == 10'(V_ACTIVE)) &&
                         ~(line_err_seen | line_err_now);
    assign frame_bad   = vfall && ~frame_good;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_event = 1'b0;
        case (state)
            SEARCH: begin
                good_nxt = 4'd0;
                if (vfall) state_nxt = MEASURE;
            end
            MEASURE: begin
                err_event = line_err_now || frame_bad;
                if (vfall && frame_good) begin
                    good_nxt = good_cnt + 4'd1;
                    if (good_nxt >= LOCK_N) state_nxt = LOCKED;
                end else if (err_event) begin
                    good_nxt = 4'd0;
                end
            end
            LOCKED: begin
                err_event = line_err_now || frame_bad;
                if (err_event) begin
                    state_nxt = MEASURE;
                    good_nxt  = 4'd0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Stage p2: measurement counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            h_count       <= 10'd0;
            pix_count     <= 10'd0;
            line_count    <= 10'd0;
            act_lines     <= 10'd0;
            line_err_seen <= 1'b0;
            pixel_valid   <= 1'b0;
            colour_out    <= 9'd0;
            x_pos         <= 10'd0;
            y_pos         <= 10'd0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            locked        <= 1'b0;
            sync_error    <= 1'b0;
            err_count     <= 8'd0;
        end else begin
            h_count       <= hfall ? 10'd0 : sat_inc10(h_count);
            pix_count     <= active ? sat_inc10(pix_base) : pix_base;
            line_count    <= vfall ? 10'd0 : line_closed;
            act_lines     <= vfall ? 10'd0 : act_closed;
            line_err_seen <= vfall ? 1'b0 : (line_err_seen | line_err_now);
            pixel_valid   <= active;
            colour_out    <= active ? colour_p0 : 9'd0;
            x_pos         <= pix_base;
            y_pos         <= vfall ? 10'd0 : act_closed;
            line_start    <= hfall;
            frame_start   <= vfall;
            locked        <= (state_nxt == LOCKED);
            sync_error    <= err_event;
            if (clear_p0)
                err_count <= 8'd0;
            else if ((state == LOCKED) && err_event)
                err_count <= sat_inc8(err_count);
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: a reduced 24x14 raster generator drives the DUT;
// directed sequences cover locking, pixel capture, line/timeout errors and reset.
`timescale 1ns/1ps
module tb_vga_sync_receiver;

    localparam int HA = 16, HT = 24, VA = 10, VT = 14, LF = 2;
    localparam int HS_W = 3, HA_START = 6, VA_START = 3;
    localparam int NV = 7;

    logic       clk = 1'b0, rst = 1'b1;
    logic       hsync = 1'b1, vsync = 1'b1, blank = 1'b1, clear_errors = 1'b0;
    logic [8:0] colour_in = 9'd0;
    logic       pixel_valid, line_start, frame_start, locked, sync_error;
    logic [8:0] colour_out;
    logic [9:0] x_pos, y_pos;
    logic [7:0] err_count;

    vga_sync_receiver #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
                        .LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank(blank),
        .colour_in(colour_in), .clear_errors(clear_errors),
        .pixel_valid(pixel_valid), .colour_out(colour_out), .x_pos(x_pos), .y_pos(y_pos),
        .line_start(line_start), .frame_start(frame_start), .locked(locked),
        .sync_error(sync_error), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         hp;
        int         vp;
        logic [8:0] col;
        logic       exp_valid;
        logic [8:0] exp_col;
        int         exp_x;
        int         exp_y;
    } vec_t;

    vec_t tab[NV];

    int   checks = 0, failures = 0;
    int   hp = 0, vp = 5, vs_hp = 10, short_vp = -1, hold_vp = -1, hold_left = 0;
    logic clr_pin = 1'b0, chk_pix = 1'b0, tab_en = 1'b0, prev_act = 1'b0, pre_locked = 1'b0;
    logic [8:0] prev_col = 9'd0;
    int   prev_hp = 0, prev_vp = 0, n_serr = 0, max_x = -1, max_y = -1, s = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One pixel clock: drive raster pins, sample the DUT after the edge, advance raster
    task automatic step();
        int         len;
        logic       act;
        logic [8:0] col;
        act = (hp >= HA_START) && (hp < HA_START + HA) && (vp >= VA_START) && (vp < VA_START + VA);
        col = {1'b1, 8'(hp * 5 + vp * 3)};
        if (tab_en)
            for (int i = 0; i < NV; i++)
                if (tab[i].hp == hp && tab[i].vp == vp) col = tab[i].col;
        hsync        = (hp >= HS_W);
        vsync        = !((vp == 0 && hp >= vs_hp) || vp == 1 || (vp == 2 && hp < vs_hp));
        blank        = !act;
        colour_in    = col;
        clear_errors = clr_pin;
        pre_locked   = locked;
        @(posedge clk);
        #1;
        if (chk_pix) begin
            check("pix_valid", int'(pixel_valid), int'(prev_act));
            if (prev_act) begin
                check("pix_colour", int'(colour_out), int'(prev_col));
                check("pix_x", int'(x_pos), prev_hp - HA_START);
                check("pix_y", int'(y_pos), prev_vp - VA_START);
                if (int'(x_pos) > max_x) max_x = int'(x_pos);
                if (int'(y_pos) > max_y) max_y = int'(y_pos);
            end else begin
                check("blank_colour", int'(colour_out), 0);
            end
        end
        if (sync_error) n_serr++;
        prev_act = act;
        prev_col = col;
        prev_hp  = hp;
        prev_vp  = vp;
        len = (vp == short_vp) ? HT - 1 : HT;
        if (vp == hold_vp && hp == HT - 1 && hold_left > 0) begin
            hold_left--;
        end else if (hp >= len - 1) begin
            hp = 0;
            if (vp == short_vp) short_vp = -1;
            if (vp == hold_vp) hold_vp = -1;
            vp = (vp + 1) % VT;
        end else begin
            hp++;
        end
    endtask

    task automatic goto(input int tvp, input int thp, input int bound);
        int n;
        n = 0;
        while (!(vp == tvp && hp == thp) && n < bound) begin
            step();
            n++;
        end
        check($sformatf("goto_%0d_%0d", tvp, thp), int'(vp == tvp && hp == thp), 1);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 3000);
        check("frame_start_seen", int'(frame_start), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pixel_valid"}, int'(pixel_valid), 0);
        check({tag, "_colour_out"}, int'(colour_out), 0);
        check({tag, "_x_pos"}, int'(x_pos), 0);
        check({tag, "_y_pos"}, int'(y_pos), 0);
        check({tag, "_line_start"}, int'(line_start), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_sync_error"}, int'(sync_error), 0);
        check({tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tab[0] = '{6,  3,  9'h1FF, 1'b1, 9'h1FF, 0,  0};
        tab[1] = '{21, 3,  9'h0AA, 1'b1, 9'h0AA, 15, 0};
        tab[2] = '{2,  5,  9'h1FF, 1'b0, 9'h000, 0,  0};
        tab[3] = '{11, 10, 9'h1A5, 1'b1, 9'h1A5, 5,  7};
        tab[4] = '{6,  12, 9'h155, 1'b1, 9'h155, 0,  9};
        tab[5] = '{20, 12, 9'h001, 1'b1, 9'h001, 14, 9};
        tab[6] = '{22, 12, 9'h1FF, 1'b0, 9'h000, 0,  0};

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;

        // Nominal stream: lock on the third vsync edge, no errors
        n_serr = 0;
        wait_frame();
        check("lock_f1", int'(locked), 0);
        chk_pix = 1'b1;
        wait_frame();
        check("lock_f2", int'(locked), 0);
        wait_frame();
        check("lock_pre_f3", int'(pre_locked), 0);
        check("lock_f3", int'(locked), 1);
        check("nominal_no_err", n_serr, 0);
        check("max_x", max_x, HA - 1);
        check("max_y", max_y, VA - 1);

        // Table-driven pixel capture in one locked frame
        tab_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            goto(tab[i].vp, tab[i].hp, 3000);
            step();
            step();
            check($sformatf("vec%0d_valid", i), int'(pixel_valid), int'(tab[i].exp_valid));
            check($sformatf("vec%0d_colour", i), int'(colour_out), int'(tab[i].exp_col));
            if (tab[i].exp_valid) begin
                check($sformatf("vec%0d_x", i), int'(x_pos), tab[i].exp_x);
                check($sformatf("vec%0d_y", i), int'(y_pos), tab[i].exp_y);
            end
        end
        check("locked_after_table", int'(locked), 1);

        // One short line while locked
        short_vp = 6;
        goto(7, 0, 3000);
        step();
        check("short_pre_err", int'(sync_error), 0);
        step();
        check("short_err", int'(sync_error), 1);
        check("short_line_start", int'(line_start), 1);
        check("short_unlock", int'(locked), 0);
        check("short_err_count", int'(err_count), 1);
        wait_frame();
        check("short_bad_frame", int'(sync_error), 1);
        check("short_err_count_hold", int'(err_count), 1);
        wait_frame();
        check("short_relock_f1", int'(locked), 0);
        wait_frame();
        check("short_relock_f2", int'(locked), 1);

        // hsync held high past counter saturation
        s = n_serr;
        hold_vp = 2;
        hold_left = 1100;
        goto(13, 0, 5000);
        check("hold_single_err", n_serr - s, 1);
        check("hold_err_count", int'(err_count), 2);
        check("hold_unlock", int'(locked), 0);
        wait_frame();
        wait_frame();
        wait_frame();
        check("hold_relock", int'(locked), 1);

        // clear_errors coincident with an error
        short_vp = 6;
        goto(7, 0, 3000);
        check("clr_before", int'(err_count), 2);
        clr_pin = 1'b1;
        step();
        clr_pin = 1'b0;
        step();
        check("clr_err_pulse", int'(sync_error), 1);
        check("clr_priority", int'(err_count), 0);
        wait_frame();
        wait_frame();
        wait_frame();
        check("clr_relock", int'(locked), 1);

        // hsync and vsync falling on the same clock
        goto(5, 0, 3000);
        vs_hp = 0;
        s = n_serr;
        wait_frame();
        check("simul_ls_f1", int'(line_start), 1);
        wait_frame();
        check("simul_ls_f2", int'(line_start), 1);
        check("simul_no_err", n_serr - s, 0);
        check("simul_locked", int'(locked), 1);

        // Reset mid-frame while locked
        goto(6, 8, 3000);
        chk_pix = 1'b0;
        rst = 1'b1;
        step();
        check_zero("midrst");
        rst = 1'b0;
        s = n_serr;
        wait_frame();
        chk_pix = 1'b1;
        check("rst_lock_f1", int'(locked), 0);
        wait_frame();
        check("rst_lock_f2", int'(locked), 0);
        wait_frame();
        check("rst_lock_f3", int'(locked), 1);
        check("rst_no_err", n_serr - s, 0);
        check("rst_err_count", int'(err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink-side counterpart to the VGA timing generator: consumes hsync/vsync/blank/colour from a VGA source and recovers pixel coordinates.
- Measures line and frame timing against the expected 640x480@60 format and declares lock after consecutive good frames.
- Used as an in-system checker/capture front end and as the bench monitor for the video path.

Parameters:
H_ACTIVE, 640, expected active (blank-low) pixels per line
H_TOTAL, 800, expected clocks between successive hsync falling edges
V_ACTIVE, 480, expected lines per frame containing active pixels
V_TOTAL, 525, expected lines (hsync falling edges) between successive vsync falling edges
LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..15)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high (decided: one clock; reset synchronous, active-high)
hsync  in  1  horizontal sync, active-low pulse
vsync  in  1  vertical sync, active-low pulse
blank  in  1  high outside active video
colour_in  in  9  rrrgggbbb pixel
clear_errors  in  1  synchronously zeroes err_count
pixel_valid  out  1  colour_out/x_pos/y_pos valid this cycle
colour_out  out  9  captured pixel, 0 when !pixel_valid
x_pos  out  10  active pixel index within line
y_pos  out  10  active line index within frame
line_start  out  1  one-cycle pulse on hsync falling edge
frame_start  out  1  one-cycle pulse on vsync falling edge
locked  out  1  timing matches parameters
sync_error  out  1  one-cycle pulse on any timing mismatch
err_count  out  8  saturating mismatch count

Behaviour:
- Input stage: all five inputs registered once. Edges detected on the registered signals (compared with a second delayed copy). All outputs are registered. Latency from the input pins to pixel_valid/colour_out/x_pos/y_pos is exactly 2 clocks. line_start and frame_start use the same 2-clock latency.
- Reset (rst=1 at a clock edge): all outputs 0, all counters 0, FSM=SEARCH. Reset mid-frame discards all partial measurements.
- h_count (10b): cleared to 0 on an hsync falling edge, otherwise increments and saturates at 1023.
  - On each hsync falling edge, line period = h_count+1. The line is good iff period==H_TOTAL and pix_count==H_ACTIVE, or pix_count==0 (blanked line: checked for period only).
  - h_count reaching 1023 without an edge is a line error (timeout), flagged once per saturation.
- pix_count / x_pos: x_pos increments per active cycle (blank low), starting at 0. Both clear on the hsync falling edge.
- line_count (10b): increments on each hsync falling edge. act_lines increments at the hsync falling edge closing a line with pix_count>0. y_pos = act_lines.
  - On a vsync falling edge, the frame is good iff line_count==V_TOTAL, act_lines==V_ACTIVE, and no line error occurred in the frame. Then line_count, act_lines and y_pos clear.
- Simultaneous hsync and vsync falling edges: close the line first (check it, count it into the ending frame), then close the frame.
- FSM:
  - SEARCH: ignore checks, clear good_cnt. On vsync falling edge -> MEASURE.
  - MEASURE: on a good frame, good_cnt++. When good_cnt reaches LOCK_FRAMES -> LOCKED, with locked=1 in the cycle after the closing vsync edge. On a bad frame or any line error, good_cnt=0 and stay in MEASURE.
  - LOCKED: any line error or bad frame -> MEASURE, with locked=0 on the next cycle and good_cnt=0.
- sync_error pulses only in MEASURE or LOCKED. In LOCKED, each error also increments err_count, saturating at 255. clear_errors has priority over a same-cycle increment.
- pixel_valid = !blank (registered), in any FSM state. colour_out is forced to 0 when !pixel_valid.

Test Plan:
- Nominal 800x525 stream (640x480 active) for 3 frames, LOCK_FRAMES=2 -> locked rises 1 clk after 3rd vsync fall. x_pos runs 0..639 and y_pos 0..479. No sync_error.
- Pixel (x=5,y=7) colour 9'h1A5 -> colour_out=9'h1A5 with x_pos=5, y_pos=7, exactly 2 clocks after input; 0 during blank.
- Once locked, one line of 799 clocks -> sync_error pulse at that hsync edge, locked falls, err_count=1. Relock after 2 further good frames.
- Hold hsync high for 1100 clocks while locked -> single sync_error at saturation, err_count+1. Assert clear_errors together with an error -> err_count=0.
- hsync and vsync falling on the same clock -> line counted into the ending frame; line_count check passes, and frame_start and line_start pulse together.
- Assert rst mid-frame while locked -> next cycle all outputs 0, FSM SEARCH. Lock requires the full sequence again.
